// File: rtl/i2c_read_sequencer_pkg.sv
// Shared types and constants for the I2C burst-read sequencer.
// Holds the FSM state encoding, the I2C address widths and the default watchdog limit.
package i2c_read_sequencer_pkg;

  localparam int DEV_ADDR_W = 7;
  localparam int REG_ADDR_W = 8;

  localparam logic [15:0] DEFAULT_TIMEOUT_CYC = 16'd40000;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_CAPTURE   = 3'd3,
    S_GAP       = 3'd4
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: the head entry is visible on pop_data whenever valid is high.
// Push while full and pop while empty are dropped; simultaneous push and pop keep occupancy.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CNT_W'(DEPTH));
  assign valid    = (count != '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && valid;
  // Masked so the data port reads zero while empty, including straight out of reset.
  assign pop_data = valid ? mem[rd_ptr] : '0;

  // NOTE: storage has no reset; only pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2c_read_sequencer.sv
// Sequences a burst of single-byte register reads through an I2C receive master,
// buffering results in a show-ahead FIFO, with a per-byte watchdog for a stuck slave.
module i2c_read_sequencer
  import i2c_read_sequencer_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [DEV_ADDR_W-1:0] i_dev_addr,
  input  logic [REG_ADDR_W-1:0] i_base_addr,
  input  logic [4:0]            i_count,
  output logic                  o_recv_en,
  output logic [DEV_ADDR_W-1:0] o_device_addr,
  output logic [REG_ADDR_W-1:0] o_data_addr,
  input  logic [7:0]            i_read_data,
  input  logic                  i_done_flag,
  output logic [7:0]            o_rd_data,
  input  logic                  i_rd_pop,
  output logic                  o_rd_valid,
  output logic                  o_busy,
  output logic                  o_burst_done,
  output logic                  o_timeout
);

  localparam logic [15:0] WD_LAST = TIMEOUT_CYC - 16'd1;

  state_e                state_q, state_d;
  logic [DEV_ADDR_W-1:0] dev_q;
  logic [REG_ADDR_W-1:0] addr_q;
  logic [4:0]            remain_q;
  logic [15:0]           wd_q;
  logic                  gap_q;
  logic                  done_q, timeout_q;
  logic                  done_d, timeout_d;
  logic                  push;
  logic                  fifo_full;
  logic                  accept;

  assign accept        = (state_q == S_IDLE) && i_start && (i_count != 5'd0);
  // Decoded from registered state, so the enable is glitch-free and the address fields
  // (which only change in IDLE and CAPTURE) are stable for the whole window.
  assign o_recv_en     = (state_q == S_WAIT_DONE);
  assign o_busy        = (state_q != S_IDLE);
  assign o_device_addr = dev_q;
  assign o_data_addr   = addr_q;
  assign o_burst_done  = done_q;
  assign o_timeout     = timeout_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d   = state_q;
    push      = 1'b0;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_count == 5'd0) done_d  = 1'b1;
          else                 state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!fifo_full) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (i_done_flag) begin
          state_d = S_CAPTURE;
        end else if (wd_q == WD_LAST) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end
      end
      S_CAPTURE: begin
        push    = 1'b1;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q) begin
          if (remain_q == 5'd0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dev_q     <= '0;
      addr_q    <= '0;
      remain_q  <= '0;
      wd_q      <= '0;
      gap_q     <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      if (accept) begin
        dev_q    <= i_dev_addr;
        addr_q   <= i_base_addr;
        remain_q <= i_count;
      end else if (state_q == S_CAPTURE) begin
        addr_q   <= addr_q + REG_ADDR_W'(1);
        remain_q <= remain_q - 5'd1;
      end
      // Watchdog restarts on every fresh entry into WAIT_DONE.
      wd_q  <= (state_q == S_WAIT_DONE && state_d == S_WAIT_DONE) ? wd_q + 16'd1 : 16'd0;
      // Two GAP cycles: first with gap_q=0, second with gap_q=1.
      gap_q <= (state_q == S_GAP) && !gap_q;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (i_read_data),
    .pop       (i_rd_pop),
    .pop_data  (o_rd_data),
    .valid     (o_rd_valid),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_i2c_read_sequencer.sv
// Self-checking bench: a register-file slave answers each read window, a scoreboard of
// expected window addresses and FIFO bytes is checked by one compare process every cycle.
module tb_i2c_read_sequencer;

  localparam int          FIFO_DEPTH  = 8;
  localparam logic [15:0] TIMEOUT_CYC = 16'd20;
  localparam int          SLAVE_LAT   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic [6:0] i_dev_addr = '0;
  logic [7:0] i_base_addr = '0;
  logic [4:0] i_count = '0;
  logic       o_recv_en;
  logic [6:0] o_device_addr;
  logic [7:0] o_data_addr;
  logic [7:0] i_read_data = '0;
  logic       i_done_flag = 1'b0;
  logic [7:0] o_rd_data;
  logic       i_rd_pop = 1'b0;
  logic       o_rd_valid;
  logic       o_busy;
  logic       o_burst_done;
  logic       o_timeout;

  i2c_read_sequencer #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_dev_addr    (i_dev_addr),
    .i_base_addr   (i_base_addr),
    .i_count       (i_count),
    .o_recv_en     (o_recv_en),
    .o_device_addr (o_device_addr),
    .o_data_addr   (o_data_addr),
    .i_read_data   (i_read_data),
    .i_done_flag   (i_done_flag),
    .o_rd_data     (o_rd_data),
    .i_rd_pop      (i_rd_pop),
    .o_rd_valid    (o_rd_valid),
    .o_busy        (o_busy),
    .o_burst_done  (o_burst_done),
    .o_timeout     (o_timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: window addresses the slave must see, bytes the FIFO must yield.
  logic [7:0] exp_addr[$];
  logic [7:0] exp_data[$];
  logic [6:0] cur_dev = '0;
  int         answer_budget = -1;
  bit         pop_en = 1'b0;
  bit         force_pop = 1'b0;
  int         windows_seen = 0;
  int         done_pulses = 0;
  int         to_pulses = 0;

  bit          sl_in_win = 1'b0;
  int          sl_lat = 0;
  logic [14:0] sl_key = '0;
  logic        prev_done = 1'b0;
  logic        prev_to = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave register file: every register reads as its address plus 0x91.
  function automatic logic [7:0] slave_reg(input logic [7:0] a);
    return a + 8'h91;
  endfunction

  task automatic plan_burst(input logic [6:0] dev, input logic [7:0] base, input int cnt);
    logic [7:0] a;
    cur_dev = dev;
    for (int k = 0; k < cnt; k++) begin
      a = base + 8'(k);
      exp_addr.push_back(a);
      exp_data.push_back(slave_reg(a));
    end
  endtask

  task automatic start(input logic [6:0] dev, input logic [7:0] base, input logic [4:0] cnt);
    @(negedge clk);
    i_start = 1'b1; i_dev_addr = dev; i_base_addr = base; i_count = cnt;
    @(negedge clk);
    i_start = 1'b0;
    i_dev_addr = 7'($urandom); i_base_addr = 8'($urandom); i_count = 5'($urandom);
  endtask

  task automatic wait_done(input int max_cyc, input string name);
    int n = 0;
    while (!o_burst_done && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(name, o_burst_done, 1);
  endtask

  task automatic drain(input string name);
    pop_en = 1'b1;
    for (int n = 0; n < 100 && exp_data.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    check({name, "_left"}, exp_data.size(), 0);
    check({name, "_empty"}, o_rd_valid, 0);
    pop_en = 1'b0;
  endtask

  // Compare process: slave responder, FIFO consumer and pulse monitor, once per cycle.
  initial begin
    forever begin
      @(negedge clk);
      i_done_flag = 1'b0;
      i_rd_pop    = force_pop;
      if (!rst_n) begin
        sl_in_win = 1'b0;
        prev_done = 1'b0;
        prev_to   = 1'b0;
      end else begin
        if (o_recv_en) begin
          if (!sl_in_win) begin
            sl_in_win = 1'b1;
            sl_lat    = 0;
            sl_key    = {o_device_addr, o_data_addr};
            windows_seen++;
            check("window_expected", 32'(exp_addr.size() != 0), 1);
            if (exp_addr.size() != 0) check("window_addr", o_data_addr, exp_addr.pop_front());
            check("window_dev", o_device_addr, cur_dev);
          end else begin
            check("addr_stable", {o_device_addr, o_data_addr}, sl_key);
          end
          if (answer_budget != 0 && sl_lat == SLAVE_LAT) begin
            i_done_flag = 1'b1;
            i_read_data = slave_reg(o_data_addr);
            if (answer_budget > 0) answer_budget--;
          end
          sl_lat++;
        end else begin
          sl_in_win = 1'b0;
        end
        if (pop_en && o_rd_valid) begin
          check("fifo_has_expected", 32'(exp_data.size() != 0), 1);
          if (exp_data.size() != 0) check("fifo_data", o_rd_data, exp_data.pop_front());
          i_rd_pop = 1'b1;
        end
        if (prev_done) check("done_width", o_burst_done, 0);
        if (prev_to)   check("timeout_width", o_timeout, 0);
        if (o_burst_done) done_pulses++;
        if (o_timeout)    to_pulses++;
        prev_done = o_burst_done;
        prev_to   = o_timeout;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, t0, w0, n, rises;
    logic prev, stuck;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_recv_en", o_recv_en, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_burst_done, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_rd_valid", o_rd_valid, 0);
    check("rst_dev_addr", o_device_addr, 0);
    check("rst_data_addr", o_data_addr, 0);
    check("rst_rd_data", o_rd_data, 0);
    rst_n = 1'b1;

    // Three-byte burst, literal expectations
    d0 = done_pulses;
    cur_dev  = 7'h50;
    exp_addr = '{8'h10, 8'h11, 8'h12};
    exp_data = '{8'hA1, 8'hA2, 8'hA3};
    start(7'h50, 8'h10, 5'd3);
    check("t1_busy_next", o_busy, 1);
    wait_done(100, "t1_done");
    check("t1_busy_at_done", o_busy, 0);
    @(negedge clk);
    check("t1_valid", o_rd_valid, 1);
    check("t1_head", o_rd_data, 8'hA1);
    drain("t1");
    check("t1_done_count", done_pulses - d0, 1);
    check("t1_addr_left", exp_addr.size(), 0);

    // Address wrap 0xFE -> 0xFF -> 0x00
    cur_dev  = 7'h23;
    exp_addr = '{8'hFE, 8'hFF, 8'h00};
    exp_data = '{8'h8F, 8'h90, 8'h91};
    start(7'h23, 8'hFE, 5'd3);
    wait_done(100, "t2_done");
    @(negedge clk);
    check("t2_head", o_rd_data, 8'h8F);
    drain("t2");
    check("t2_addr_left", exp_addr.size(), 0);

    // FIFO-full stall with 16 bytes and no consumer, then resume
    w0 = windows_seen;
    plan_burst(7'h2A, 8'h40, 16);
    start(7'h2A, 8'h40, 5'd16);
    repeat (120) @(negedge clk);
    check("t3_stall_windows", windows_seen - w0, FIFO_DEPTH);
    check("t3_stall_recv_en", o_recv_en, 0);
    check("t3_stall_busy", o_busy, 1);
    stuck = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (o_recv_en) stuck = 1'b1;
    end
    check("t3_stall_hold", stuck, 0);
    pop_en = 1'b1;
    n = 0;
    while (!o_recv_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t3_resume", o_recv_en, 1);
    wait_done(300, "t3_done");
    drain("t3");
    check("t3_windows_total", windows_seen - w0, 16);

    // Zero-length burst, pop on empty, start while busy
    d0 = done_pulses;
    w0 = windows_seen;
    start(7'h11, 8'h00, 5'd0);
    check("t4_cnt0_done", o_burst_done, 1);
    check("t4_cnt0_busy", o_busy, 0);
    force_pop = 1'b1;
    repeat (3) @(negedge clk);
    force_pop = 1'b0;
    repeat (10) @(negedge clk);
    check("t4_cnt0_no_window", windows_seen - w0, 0);
    check("t4_pop_empty_valid", o_rd_valid, 0);
    plan_burst(7'h11, 8'h80, 2);
    start(7'h11, 8'h80, 5'd2);
    check("t4_busy", o_busy, 1);
    repeat (3) @(negedge clk);
    i_start = 1'b1; i_dev_addr = 7'h7F; i_base_addr = 8'h00; i_count = 5'd5;
    @(negedge clk);
    i_start = 1'b0;
    pop_en = 1'b1;
    wait_done(100, "t4_done");
    drain("t4");
    repeat (30) @(negedge clk);
    check("t4_windows", windows_seen - w0, 2);
    check("t4_done_count", done_pulses - d0, 2);

    // NACK on second byte: watchdog abort, first byte kept
    d0 = done_pulses;
    t0 = to_pulses;
    answer_budget = 1;
    plan_burst(7'h42, 8'h30, 1);
    exp_addr.push_back(8'h31);
    start(7'h42, 8'h30, 5'd2);
    rises = 0; prev = 1'b0; n = 0;
    while (rises < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (o_recv_en && !prev) rises++;
      prev = o_recv_en;
    end
    check("t5_second_window", rises, 2);
    n = 0;
    while (!o_timeout && n < int'(TIMEOUT_CYC) + 10) begin
      @(negedge clk);
      n++;
    end
    check("t5_timeout_latency", n, TIMEOUT_CYC);
    check("t5_recv_en_dropped", o_recv_en, 0);
    check("t5_busy", o_busy, 0);
    @(negedge clk);
    check("t5_timeout_single", o_timeout, 0);
    repeat (5) @(negedge clk);
    check("t5_no_done", done_pulses - d0, 0);
    check("t5_timeout_count", to_pulses - t0, 1);
    check("t5_kept_valid", o_rd_valid, 1);
    check("t5_kept_head", o_rd_data, 8'hC1);
    answer_budget = -1;
    drain("t5");

    // Reset during the second byte of a four-byte burst
    d0 = done_pulses;
    t0 = to_pulses;
    plan_burst(7'h33, 8'h60, 4);
    start(7'h33, 8'h60, 5'd4);
    rises = 0; prev = 1'b0; n = 0;
    while (rises < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (o_recv_en && !prev) rises++;
      prev = o_recv_en;
    end
    check("t6_second_window", rises, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_recv_en", o_recv_en, 0);
    check("t6_busy", o_busy, 0);
    check("t6_done", o_burst_done, 0);
    check("t6_timeout", o_timeout, 0);
    check("t6_rd_valid", o_rd_valid, 0);
    check("t6_dev_addr", o_device_addr, 0);
    check("t6_data_addr", o_data_addr, 0);
    check("t6_rd_data", o_rd_data, 0);
    exp_addr.delete();
    exp_data.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_no_done", done_pulses - d0, 0);
    check("t6_no_timeout", to_pulses - t0, 0);
    check("t6_fifo_empty", o_rd_valid, 0);
    check("t6_idle", o_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_read_sequencer.md
I2C_READ_SEQUENCER -- requirements
Module: i2c_read_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, the read-data FIFO depth; legal values are powers of two, 2..16.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16'd40000, the clk cycles allowed per byte transaction before abort.
REQ-003 SHALL have port clk, input, 1 bit, system clock (50 MHz).
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port i_start, input, 1 bit, single-cycle burst request.
REQ-006 SHALL have port i_dev_addr, input, 7 bits, slave device address.
REQ-007 SHALL have port i_base_addr, input, 8 bits, first register address.
REQ-008 SHALL have port i_count, input, 5 bits, bytes to read (0..16).
REQ-009 SHALL have port o_recv_en, output, 1 bit, enable to the I2C receive master.
REQ-010 SHALL have ports o_device_addr (7 bits) and o_data_addr (8 bits), outputs, address fields to the master.
REQ-011 SHALL have ports i_read_data (8 bits) and i_done_flag (1 bit), inputs, the master's result and completion signals.
REQ-012 SHALL have ports o_rd_data (8 bits, output), i_rd_pop (1 bit, input) and o_rd_valid (1 bit, output), the FIFO consumer side; this is a show-ahead FIFO.
REQ-013 SHALL have outputs o_busy, o_burst_done and o_timeout, each 1 bit.

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT_DONE, CAPTURE, GAP.
REQ-015 IDLE, i_start=1, i_count≠0 -> latch dev/base/count, go to ISSUE; o_busy=1 from the next cycle.
REQ-016 IDLE, i_start=1, i_count=0 -> one-cycle o_burst_done pulse; no transaction; stay in IDLE.
REQ-017 i_start outside IDLE is ignored; latched fields do not change.
REQ-018 ISSUE: when FIFO not full, drive o_recv_en=1 with the current address and go to WAIT_DONE; when full, stall in ISSUE with o_recv_en=0.
REQ-019 o_device_addr and o_data_addr SHALL be stable for the whole time o_recv_en=1.
REQ-020 WAIT_DONE: hold o_recv_en=1 until i_done_flag=1, then go to CAPTURE.
REQ-021 CAPTURE (1 cycle): push i_read_data into the FIFO, increment the address mod 256 (8'hFF -> 8'h00), decrement the remaining count, drop o_recv_en, go to GAP.
REQ-022 GAP: keep o_recv_en=0 for exactly 2 cycles so the master returns to its idle state.
REQ-023 GAP exit: remaining count ≠0 -> ISSUE; remaining count =0 -> IDLE with a one-cycle o_burst_done pulse.
REQ-024 Watchdog: count cycles in WAIT_DONE; on reaching TIMEOUT_CYC (e.g. slave NACK), drop o_recv_en, pulse o_timeout for 1 cycle, go to IDLE.
REQ-025 On timeout, o_burst_done is not asserted and bytes already in the FIFO are kept.
REQ-026 FIFO push on a full FIFO is impossible by construction (REQ-018).
REQ-027 Pop on an empty FIFO SHALL be ignored.
REQ-028 Push and pop in the same cycle SHALL leave the occupancy unchanged.
REQ-029 o_rd_valid = occupancy≠0; o_rd_data = head entry, combinational from storage.
REQ-030 Occupancy counter width SHALL be $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-031 rst_n low SHALL asynchronously force: state IDLE; o_recv_en, o_busy, o_burst_done, o_timeout, o_rd_valid = 0; o_device_addr, o_data_addr, o_rd_data = 0; FIFO empty; watchdog = 0.
REQ-032 Reset mid-burst SHALL abandon the burst with no done or timeout pulse, and the master is released because o_recv_en=0.

Structure
REQ-033 The shared package SHALL hold the state encoding, the default TIMEOUT_CYC, and the I2C address widths (7 and 8).
REQ-034 The FIFO SHALL be a sub-module, sync_fifo, parameterised by width and depth; the FSM and watchdog stay in the top module.

Verification
REQ-035 start, dev 7'h50, base 8'h10, count 3, with a slave model returning 8'hA1, 8'hA2, 8'hA3 -> three o_recv_en windows with o_data_addr 8'h10, 8'h11, 8'h12; FIFO yields A1, A2, A3; one o_burst_done pulse.
REQ-036 base 8'hFE, count 3 -> o_data_addr sequence 8'hFE, 8'hFF, 8'h00.
REQ-037 FIFO_DEPTH 8, count 16, no pops until 8 bytes captured -> stalls in ISSUE with o_recv_en=0; resumes after the first pop; all 16 bytes arrive in order.
REQ-038 slave NACKs the address (i_done_flag never rises) -> o_timeout pulses exactly TIMEOUT_CYC cycles after ISSUE exit; o_busy=0; no o_burst_done.
REQ-039 count 0 -> o_burst_done on the next cycle and o_recv_en never asserted; i_start while busy -> ignored.
REQ-040 rst_n asserted during the second byte of a count-4 burst -> all outputs 0 immediately; FIFO empty.
